// File: rtl/vending_fsm_change.sv
// Parametrised vending controller: per-product prices, bounded credit,
// greedy change return through a hopper handshake, and cancel/refund.
module vending_fsm_change #(
    parameter int                      N_PROD     = 4,
    parameter int                      PRICE_W    = 8,
    parameter logic [N_PROD*PRICE_W-1:0] PRICES   = {8'd10, 8'd7, 8'd5, 8'd3},
    parameter int                      CREDIT_W   = 8,
    parameter int                      MAX_CREDIT = 40,
    localparam int                     SEL_W      = (N_PROD > 1) ? $clog2(N_PROD) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                coin_valid,
    input  logic [1:0]          coin,
    input  logic                sel_valid,
    input  logic [SEL_W-1:0]    sel,
    input  logic                cancel,
    input  logic                change_ready,
    output logic                product_valid,
    output logic [SEL_W-1:0]    product_id,
    output logic                change_valid,
    output logic [1:0]          change_coin,
    output logic                coin_reject,
    output logic                sel_denied,
    output logic [CREDIT_W-1:0] credit,
    output logic                busy
);
    localparam int SW = CREDIT_W + 1;

    typedef enum logic [1:0] {IDLE, COLLECT, VEND, CHANGE} state_t;

    state_t              state, state_nxt;
    logic [CREDIT_W-1:0] credit_nxt;
    logic [SEL_W-1:0]    pid_nxt;
    logic                rej_nxt, den_nxt;

    logic [2:0]          coin_v;
    logic [SW-1:0]       credit_x, sum_x, price_x;
    logic [PRICE_W-1:0]  sel_price;
    logic                sel_ok;
    logic [2:0]          chg_v;
    logic [1:0]          chg_coin;

    always_comb begin
        case (coin)
            2'b01:   coin_v = 3'd1;
            2'b10:   coin_v = 3'd2;
            2'b11:   coin_v = 3'd5;
            default: coin_v = 3'd0;
        endcase
    end

    // Loop lookup keeps out-of-range indices (non-power-of-two N_PROD) off the table.
    always_comb begin
        sel_price = '0;
        sel_ok    = 1'b0;
        for (int i = 0; i < N_PROD; i++) begin
            if (sel == SEL_W'(i)) begin
                sel_price = PRICES[i*PRICE_W +: PRICE_W];
                sel_ok    = 1'b1;
            end
        end
    end

    assign credit_x = {1'b0, credit};
    assign sum_x    = credit_x + SW'(coin_v);
    assign price_x  = SW'(sel_price);

    always_comb begin
        if (credit >= CREDIT_W'(5)) begin
            chg_v = 3'd5; chg_coin = 2'b11;
        end else if (credit >= CREDIT_W'(2)) begin
            chg_v = 3'd2; chg_coin = 2'b10;
        end else begin
            chg_v = 3'd1; chg_coin = 2'b01;
        end
    end

    always_comb begin
        state_nxt  = state;
        credit_nxt = credit;
        pid_nxt    = product_id;
        rej_nxt    = 1'b0;
        den_nxt    = 1'b0;
        case (state)
            IDLE, COLLECT: begin
                // Any coin that loses priority to cancel/sel is diverted, never silently kept.
                if (cancel && credit != '0) begin
                    state_nxt = CHANGE;
                    rej_nxt   = coin_valid;
                end else if (sel_valid) begin
                    rej_nxt = coin_valid;
                    if (!sel_ok || credit_x < price_x) begin
                        den_nxt = 1'b1;
                    end else begin
                        credit_nxt = CREDIT_W'(credit_x - price_x);
                        pid_nxt    = sel;
                        state_nxt  = VEND;
                    end
                end else if (coin_valid) begin
                    if (coin_v != 3'd0 && sum_x <= SW'(MAX_CREDIT)) begin
                        credit_nxt = CREDIT_W'(sum_x);
                        state_nxt  = COLLECT;
                    end else begin
                        rej_nxt = 1'b1;
                    end
                end
            end
            VEND: begin
                rej_nxt   = coin_valid;
                state_nxt = (credit != '0) ? CHANGE : IDLE;
            end
            CHANGE: begin
                rej_nxt = coin_valid;
                if (change_ready) begin
                    credit_nxt = credit - CREDIT_W'(chg_v);
                    if (credit_nxt == '0) state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            credit      <= '0;
            product_id  <= '0;
            coin_reject <= 1'b0;
            sel_denied  <= 1'b0;
        end else begin
            state       <= state_nxt;
            credit      <= credit_nxt;
            product_id  <= pid_nxt;
            coin_reject <= rej_nxt;
            sel_denied  <= den_nxt;
        end
    end

    // Coin choice depends only on credit, which moves only on a handshake,
    // so it holds steady under backpressure.
    assign product_valid = (state == VEND);
    assign change_valid  = (state == CHANGE);
    assign change_coin   = change_valid ? chg_coin : 2'b00;
    assign busy          = (state == VEND) || (state == CHANGE);
endmodule

// File: tb/tb_vending_fsm_change.sv
// Directed bench for vending_fsm_change: default 4-product table plus a
// 3-product instance driven in lockstep to cover out-of-range selection.
module tb_vending_fsm_change;
    logic       clk = 1'b0;
    logic       rst, coin_valid, sel_valid, cancel, change_ready;
    logic [1:0] coin, sel;

    logic       product_valid, change_valid, coin_reject, sel_denied, busy;
    logic [1:0] product_id, change_coin;
    logic [7:0] credit;
    logic       product_valid3, change_valid3, coin_reject3, sel_denied3, busy3;
    logic [1:0] product_id3, change_coin3;
    logic [7:0] credit3;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    vending_fsm_change dut (
        .clk(clk), .rst(rst), .coin_valid(coin_valid), .coin(coin),
        .sel_valid(sel_valid), .sel(sel), .cancel(cancel), .change_ready(change_ready),
        .product_valid(product_valid), .product_id(product_id),
        .change_valid(change_valid), .change_coin(change_coin),
        .coin_reject(coin_reject), .sel_denied(sel_denied), .credit(credit), .busy(busy)
    );

    vending_fsm_change #(.N_PROD(3), .PRICES({8'd7, 8'd5, 8'd3})) dut3 (
        .clk(clk), .rst(rst), .coin_valid(coin_valid), .coin(coin),
        .sel_valid(sel_valid), .sel(sel), .cancel(cancel), .change_ready(change_ready),
        .product_valid(product_valid3), .product_id(product_id3),
        .change_valid(change_valid3), .change_coin(change_coin3),
        .coin_reject(coin_reject3), .sel_denied(sel_denied3), .credit(credit3), .busy(busy3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Apply the driven inputs across one edge, then drop the strobes.
    task automatic tick();
        @(posedge clk);
        #1;
        coin_valid = 1'b0;
        sel_valid  = 1'b0;
        cancel     = 1'b0;
    endtask

    task automatic put_coin(input logic [1:0] c);
        coin_valid = 1'b1;
        coin       = c;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; coin_valid = 0; coin = 0; sel_valid = 0; sel = 0;
        cancel = 0; change_ready = 0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_credit", credit, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pv", product_valid, 0);
        chk("rst_cv", change_valid, 0);
        chk("rst_coin", change_coin, 0);
        chk("rst_pid", product_id, 0);
        chk("rst_rej", coin_reject, 0);
        chk("rst_den", sel_denied, 0);

        // Exact-credit vend of product 0 (price 3)
        put_coin(2'b01);
        chk("t1_credit1", credit, 1);
        put_coin(2'b10);
        chk("t1_credit3", credit, 3);
        sel_valid = 1; sel = 0; tick();
        chk("t1_pv", product_valid, 1);
        chk("t1_pid", product_id, 0);
        chk("t1_credit0", credit, 0);
        chk("t1_cv_vend", change_valid, 0);
        tick();
        chk("t1_pv_drop", product_valid, 0);
        chk("t1_cv_after", change_valid, 0);
        chk("t1_idle", busy, 0);

        // Product 2 (price 7) with change: dime then nickel
        change_ready = 1;
        put_coin(2'b11);
        put_coin(2'b11);
        chk("t2_credit10", credit, 10);
        sel_valid = 1; sel = 2; tick();
        chk("t2_pv", product_valid, 1);
        chk("t2_pid", product_id, 2);
        chk("t2_credit3", credit, 3);
        tick();
        chk("t2_cv1", change_valid, 1);
        chk("t2_dime", change_coin, 2'b10);
        tick();
        chk("t2_credit1", credit, 1);
        chk("t2_nickel", change_coin, 2'b01);
        tick();
        chk("t2_credit0", credit, 0);
        chk("t2_cv_drop", change_valid, 0);
        chk("t2_idle", busy, 0);

        // Overflow: eight quarters fill to 40, ninth and invalid coin rejected
        for (int i = 0; i < 8; i++) put_coin(2'b11);
        chk("t3_credit40", credit, 40);
        chk("t3_no_rej", coin_reject, 0);
        put_coin(2'b11);
        chk("t3_rej_ovf", coin_reject, 1);
        chk("t3_hold40", credit, 40);
        put_coin(2'b00);
        chk("t3_rej_inv", coin_reject, 1);
        chk("t3_hold40b", credit, 40);
        cancel = 1; tick();
        chk("t3_refund_cv", change_valid, 1);
        for (int i = 0; i < 8; i++) tick();
        chk("t3_refund_done", credit, 0);
        chk("t3_refund_idle", busy, 0);

        // Denied selections at credit 4
        put_coin(2'b10);
        put_coin(2'b10);
        chk("t4_credit4", credit, 4);
        sel_valid = 1; sel = 1; tick();
        chk("t4_den_price", sel_denied, 1);
        chk("t4_credit_kept", credit, 4);
        chk("t4_no_pv", product_valid, 0);
        sel_valid = 1; sel = 3; tick();
        chk("t4_den_range3", sel_denied3, 1);
        chk("t4_credit3_kept", credit3, 4);
        chk("t4_busy3", busy3, 0);
        tick();
        chk("t4_den_drop", sel_denied, 0);

        // Cancel with hopper backpressure at credit 7
        change_ready = 0;
        put_coin(2'b10);
        put_coin(2'b01);
        chk("t5_credit7", credit, 7);
        cancel = 1; tick();
        for (int i = 0; i < 3; i++) begin
            if (i == 1) begin coin_valid = 1; coin = 2'b01; end
            chk("t5_hold_cv", change_valid, 1);
            chk("t5_hold_q", change_coin, 2'b11);
            chk("t5_hold_cr", credit, 7);
            tick();
            if (i == 1) begin
                chk("t5_busy_rej", coin_reject, 1);
                chk("t5_busy_cr", credit, 7);
            end
        end
        change_ready = 1;
        tick();
        chk("t5_credit2", credit, 2);
        chk("t5_dime", change_coin, 2'b10);
        tick();
        chk("t5_credit0", credit, 0);
        chk("t5_cv_drop", change_valid, 0);

        // Simultaneous cancel + sel + coin: refund only
        change_ready = 0;
        put_coin(2'b11);
        chk("t6_credit5", credit, 5);
        cancel = 1; sel_valid = 1; sel = 0; coin_valid = 1; coin = 2'b01;
        tick();
        chk("t6_cv", change_valid, 1);
        chk("t6_rej", coin_reject, 1);
        chk("t6_no_pv", product_valid, 0);
        chk("t6_no_den", sel_denied, 0);
        chk("t6_credit", credit, 5);

        // Reset mid-CHANGE abandons the refund
        rst = 1; tick(); rst = 0;
        chk("t6_rst_credit", credit, 0);
        chk("t6_rst_cv", change_valid, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_coin", change_coin, 0);
        put_coin(2'b01);
        chk("t6_after_rst", credit, 1);
        chk("t6_after_rst3", credit3, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
